// File: rtl/fp16_pkg.sv
// Shared binary16 constants and pipeline payload types for the normalise/round stage.
package fp16_pkg;

    localparam int          EXP_BIAS = 15;
    localparam int          EXP_MAX  = 31;
    localparam logic [15:0] QNAN     = 16'h7E00;
    localparam logic [15:0] POS_INF  = 16'h7C00;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exponent;
        logic [13:0] magnitude;
        logic        inf;
        logic        nan;
    } fp_payload_t;

    // Normalised significand with hidden bit at [10]; tiny marks an exponent that fell to <= 0.
    typedef struct packed {
        logic              sign;
        logic signed [6:0] e;
        logic [10:0]       sig;
        logic              guard;
        logic              sticky;
        logic              tiny;
        logic              zero;
        logic              inf;
        logic              nan;
    } fp_norm_t;

endpackage

// File: rtl/fp_lzc14.sv
// Combinational 14-bit leading-zero counter; count is 14 and all_zero is set for a zero input.
module fp_lzc14 (
    input  logic [13:0] value,
    output logic [3:0]  count,
    output logic        all_zero
);

    always_comb begin
        count = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (value[i]) begin
                count = 4'(13 - i);
            end
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/fp_normalize_round.sv
// Three-stage normalise / round-to-nearest-even / pack stage producing binary16 plus status flags.
// FP_NORM_SUBNORMAL_EN enables gradual underflow; without it tiny results flush to signed zero.
module fp_normalize_round
    import fp16_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exponent,
    input  logic [MAN_W+3:0] in_magnitude,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic [15:0]      r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             negative,
    output logic             overflow,
    output logic             underflow,
    output logic             zero,
    output logic             inexact
);

    logic        adv;
    logic [3:0]  lzc_count;
    logic        lzc_all_zero;

    logic        s1_valid_q, s1_valid_d;
    fp_payload_t s1_payload_q, s1_payload_d;
    logic [3:0]  s1_lzc_q, s1_lzc_d;
    logic        s1_carry_q, s1_carry_d;
    logic        s1_zero_q, s1_zero_d;

    logic        s2_valid_q, s2_valid_d;
    fp_norm_t    s2_q, s2_d, norm;
    logic [12:0] norm_shifted;

    logic        out_valid_q, out_valid_d;
    logic [15:0] r_q, r_d;
    logic        negative_q, negative_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic        zero_q, zero_d, inexact_q, inexact_d;

    logic              round_up, rnd_inexact, underflow_bit, flush;
    logic [11:0]       rounded;
    logic signed [6:0] rnd_e;
    logic [4:0]        pack_exp;

`ifdef FP_NORM_SUBNORMAL_EN
    logic signed [6:0] sub_dist;
    logic [3:0]        sub_amt;
    logic [25:0]       sub_wide;
`endif

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Padding with a trailing zero makes the count equal the leading zeros of magnitude[12:0].
    fp_lzc14 u_lzc (
        .value    ({in_magnitude[12:0], 1'b0}),
        .count    (lzc_count),
        .all_zero (lzc_all_zero)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_payload_d = s1_payload_q;
        s1_lzc_d     = s1_lzc_q;
        s1_carry_d   = s1_carry_q;
        s1_zero_d    = s1_zero_q;
        if (adv) begin
            s1_valid_d             = in_valid;
            s1_payload_d.sign      = in_sign;
            s1_payload_d.exponent  = in_exponent;
            s1_payload_d.magnitude = in_magnitude;
            s1_payload_d.inf       = in_inf;
            s1_payload_d.nan       = in_nan;
            s1_lzc_d               = lzc_all_zero ? 4'd13 : lzc_count;
            s1_carry_d             = in_magnitude[13];
            s1_zero_d              = lzc_all_zero && !in_magnitude[13];
        end
    end

    always_comb begin
        norm         = '0;
        norm.sign    = s1_payload_q.sign;
        norm.zero    = s1_zero_q;
        norm.inf     = s1_payload_q.inf;
        norm.nan     = s1_payload_q.nan;
        norm_shifted = s1_payload_q.magnitude[12:0] << s1_lzc_q;
`ifdef FP_NORM_SUBNORMAL_EN
        sub_dist     = '0;
        sub_amt      = '0;
        sub_wide     = '0;
`endif
        if (s1_carry_q) begin
            norm.sig    = s1_payload_q.magnitude[13:3];
            norm.guard  = s1_payload_q.magnitude[2];
            norm.sticky = |s1_payload_q.magnitude[1:0];
            norm.e      = {2'b00, s1_payload_q.exponent} + 7'd1;
        end else begin
            norm.sig    = norm_shifted[12:2];
            norm.guard  = norm_shifted[1];
            norm.sticky = norm_shifted[0];
            norm.e      = {2'b00, s1_payload_q.exponent} - {3'b000, s1_lzc_q};
        end
        if (norm.e <= 7'sd0) begin
            norm.tiny = 1'b1;
`ifdef FP_NORM_SUBNORMAL_EN
            // Denormalise into G/S; e=1 without a hidden bit packs as exponent field 0.
            sub_dist    = 7'sd1 - norm.e;
            sub_amt     = (sub_dist > 7'sd13) ? 4'd13 : sub_dist[3:0];
            sub_wide    = {norm.sig, norm.guard, norm.sticky, 13'd0} >> sub_amt;
            norm.sig    = sub_wide[25:15];
            norm.guard  = sub_wide[14];
            norm.sticky = sub_wide[13] | (|sub_wide[12:0]);
            norm.e      = 7'sd1;
`endif
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_d       = norm;
        end
    end

    always_comb begin
        round_up    = s2_q.guard & (s2_q.sticky | s2_q.sig[0]);
        rounded     = {1'b0, s2_q.sig} + {11'd0, round_up};
        rnd_e       = s2_q.e + {6'd0, rounded[11]};
        rnd_inexact = s2_q.guard | s2_q.sticky;
        pack_exp    = (rounded[11] | rounded[10]) ? rnd_e[4:0] : 5'd0;
`ifdef FP_NORM_SUBNORMAL_EN
        underflow_bit = s2_q.tiny & rnd_inexact;
        flush         = 1'b0;
`else
        underflow_bit = 1'b0;
        flush         = s2_q.tiny;
`endif

        out_valid_d = out_valid_q;
        r_d         = r_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
        end
        // Output registers only load real beats so bubbles never disturb the last result.
        if (adv && s2_valid_q) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            inexact_d   = 1'b0;
            if (s2_q.nan) begin
                r_d = QNAN;
            end else if (s2_q.inf) begin
                r_d = {s2_q.sign, POS_INF[14:0]};
            end else if (s2_q.zero) begin
                r_d = 16'h0000;
            end else if (flush) begin
                r_d         = {s2_q.sign, 15'h0000};
                underflow_d = 1'b1;
                inexact_d   = 1'b1;
            end else if (rnd_e >= 7'(EXP_MAX)) begin
                r_d        = {s2_q.sign, POS_INF[14:0]};
                overflow_d = 1'b1;
                inexact_d  = 1'b1;
            end else begin
                r_d         = {s2_q.sign, pack_exp, rounded[9:0]};
                inexact_d   = rnd_inexact;
                underflow_d = underflow_bit;
            end
        end
        negative_d = r_d[15];
        zero_d     = (adv && s2_valid_q) ? ~|r_d[14:0] : zero_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_payload_q <= '0;
            s1_lzc_q     <= '0;
            s1_carry_q   <= 1'b0;
            s1_zero_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_q         <= '0;
            out_valid_q  <= 1'b0;
            r_q          <= 16'h0000;
            negative_q   <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            zero_q       <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_payload_q <= s1_payload_d;
            s1_lzc_q     <= s1_lzc_d;
            s1_carry_q   <= s1_carry_d;
            s1_zero_q    <= s1_zero_d;
            s2_valid_q   <= s2_valid_d;
            s2_q         <= s2_d;
            out_valid_q  <= out_valid_d;
            r_q          <= r_d;
            negative_q   <= negative_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            zero_q       <= zero_d;
            inexact_q    <= inexact_d;
        end
    end

    assign r         = r_q;
    assign out_valid = out_valid_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign zero      = zero_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed self-checking bench for fp_normalize_round: vectors, stall/order and mid-stall reset.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_inf, in_nan;
    logic [4:0]  in_exponent;
    logic [13:0] in_magnitude;
    logic [15:0] r;
    logic        out_valid, out_ready;
    logic        negative, overflow, underflow, zero, inexact;

    int checks   = 0;
    int failures = 0;

    logic [15:0] stall_exp [4];

    fp_normalize_round dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exponent  (in_exponent),
        .in_magnitude (in_magnitude),
        .in_inf       (in_inf),
        .in_nan       (in_nan),
        .r            (r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .negative     (negative),
        .overflow     (overflow),
        .underflow    (underflow),
        .zero         (zero),
        .inexact      (inexact)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Sends one beat with out_ready high, then checks latency, result and {neg,ovf,unf,zero,inex}.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [4:0] ex,
                                 input logic [13:0] mag, input logic inf, input logic nan,
                                 input logic [15:0] exp_r, input logic [4:0] exp_flags);
        int cycles;
        @(negedge clk);
        in_valid     = 1'b1;
        in_sign      = sgn;
        in_exponent  = ex;
        in_magnitude = mag;
        in_inf       = inf;
        in_nan       = nan;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cycles < 10) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, cycles, 3);
        checkOutput({tag, "_r"}, r, exp_r);
        checkOutput({tag, "_flags"}, {negative, overflow, underflow, zero, inexact}, exp_flags);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx, got, vcount;
        logic acc;

        stall_exp[0] = 16'h3C00;
        stall_exp[1] = 16'h4000;
        stall_exp[2] = 16'h4400;
        stall_exp[3] = 16'h4800;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_sign      = 1'b0;
        in_exponent  = '0;
        in_magnitude = '0;
        in_inf       = 1'b0;
        in_nan       = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_r", r, 16'h0000);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_flags", {negative, overflow, underflow, zero, inexact}, 5'b00000);
        checkOutput("reset_in_ready", in_ready, 1'b1);

        applyStimulus("one",      1'b0, 5'd15, 14'b01_0000000000_00, 1'b0, 1'b0, 16'h3C00, 5'b00000);
        applyStimulus("carry",    1'b0, 5'd15, 14'b10_0000000000_00, 1'b0, 1'b0, 16'h4000, 5'b00000);
        applyStimulus("cancel",   1'b0, 5'd15, 14'b00_0000000001_00, 1'b0, 1'b0, 16'h1400, 5'b00000);
        applyStimulus("rnd_up",   1'b0, 5'd15, 14'b01_0000000001_10, 1'b0, 1'b0, 16'h3C02, 5'b00001);
        applyStimulus("rnd_tie",  1'b0, 5'd15, 14'b01_0000000000_10, 1'b0, 1'b0, 16'h3C00, 5'b00001);
        applyStimulus("overflow", 1'b0, 5'd30, 14'b11_1111111111_11, 1'b0, 1'b0, 16'h7C00, 5'b01001);
`ifdef FP_NORM_SUBNORMAL_EN
        applyStimulus("tiny",     1'b0, 5'd1,  14'b00_1000000000_00, 1'b0, 1'b0, 16'h0200, 5'b00000);
`else
        applyStimulus("tiny",     1'b0, 5'd1,  14'b00_1000000000_00, 1'b0, 1'b0, 16'h0000, 5'b00111);
`endif
        applyStimulus("nan",      1'b1, 5'd15, 14'b01_0000000000_00, 1'b1, 1'b1, 16'h7E00, 5'b00000);
        applyStimulus("neg_inf",  1'b1, 5'd15, 14'b01_0000000000_00, 1'b1, 1'b0, 16'hFC00, 5'b10000);
        applyStimulus("zero_mag", 1'b1, 5'd15, 14'b00_0000000000_00, 1'b0, 1'b0, 16'h0000, 5'b00010);
        applyStimulus("neg_one",  1'b1, 5'd15, 14'b01_0000000000_00, 1'b0, 1'b0, 16'hBC00, 5'b10000);

        // Four beats into a stalled output, held for five cycles, then drained in order.
        idx = 0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = (c >= 8);
            in_sign   = 1'b0;
            in_inf    = 1'b0;
            in_nan    = 1'b0;
            if (idx < 4) begin
                in_valid     = 1'b1;
                in_exponent  = 5'(15 + idx);
                in_magnitude = 14'b01_0000000000_00;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 3) begin
                checkOutput("stall_valid", out_valid, 1'b1);
                checkOutput("stall_in_ready", in_ready, 1'b0);
                checkOutput("stall_r", r, 16'h3C00);
            end
            if (c == 7) begin
                checkOutput("stall_hold_r", r, 16'h3C00);
                checkOutput("stall_hold_in_ready", in_ready, 1'b0);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    checkOutput("stall_order", r, stall_exp[got]);
                end
                got++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        checkOutput("stall_sent", idx, 4);
        checkOutput("stall_received", got, 4);

        // Fill the pipeline behind a stalled output, then reset asynchronously.
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            in_exponent  = 5'd20;
            in_magnitude = 14'b01_0000000000_00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", out_valid, 1'b1);
        checkOutput("pre_reset_r", r, 16'h5000);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_valid", out_valid, 1'b0);
        checkOutput("mid_reset_r", r, 16'h0000);
        checkOutput("mid_reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        vcount    = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        checkOutput("post_reset_discard", vcount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Downstream stage of the half-precision fp_adder_subtractor datapath.
- Consumes the raw post-addition magnitude, result sign and larger exponent.
- Normalises, rounds to nearest-even and packs an IEEE 754 binary16 result with status flags.
- 3-stage pipeline with valid/ready handshake, so the combinational adder front-end can be registered into it.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width. Magnitude input width is MAN_W+4.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sign  input  1  sign of the unnormalised result.
- in_exponent  input  EXP_W  larger operand exponent (biased).
- in_magnitude  input  MAN_W+4  [13]=carry, [12]=hidden, [11:2]=fraction, [1]=guard, [0]=sticky.
- in_inf  input  1  operand infinity; forces infinity output.
- in_nan  input  1  NaN or inf-inf; forces NaN output (priority over in_inf).
- r  output  16  packed binary16 result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- negative, overflow, underflow, zero, inexact  output  1 each  status flags aligned with r.

Behaviour:
- Reset (async, active-high): all stage valids 0, r=16'h0000, all flags 0, out_valid=0. Reset mid-stall discards every in-flight beat.
- Handshake:
  - Global advance enable adv = !out_valid | out_ready; in_ready = adv.
  - A beat transfers when in_valid & in_ready.
  - Pipeline does not compress bubbles.
  - Outputs are held stable while out_valid & !out_ready.
- Latency: 3 clk from input transfer to out_valid, when never stalled. Throughput: 1 beat/clk.
- S1, classify/LZC:
  - Register the leading-zero count of in_magnitude[12:0] (0..13).
  - Register a carry flag (bit13), a zero flag (magnitude==0) and the specials.
- S2, normalise. Exponent is held internally as 7-bit signed e.
  - carry=1: shift right 1, sticky |= dropped bit, e=in_exponent+1.
  - carry=0: shift left lzc, e=in_exponent-lzc.
  - If e<=0: underflow path (see Optional Feature).
- S3, round/pack:
  - round_up = G & (S | lsb) (round to nearest, ties to even).
  - If the fraction wraps from all ones: fraction=0, e+1.
  - If e>=31: r={sign,5'h1F,10'h0}, overflow=1, inexact=1.
  - inexact = G|S before rounding.
- Specials:
  - nan gives r=16'h7E00, negative=0, no other flags.
  - inf gives r={in_sign,15'h7C00}, negative=in_sign.
- Exact zero magnitude: r=16'h0000 (+0), zero=1, negative=0.
- negative = r[15]; zero = (r[14:0]==0).

Optional Feature:
- Macro FP_NORM_SUBNORMAL_EN.
- Defined: e<=0 right-shifts the 11-bit significand by (1-e) into G/S (sticky accumulates, shift saturates at 13), then rounds normally with exponent field 0. underflow=1 only if the result is tiny and inexact. Rounding up into 1.0×2^-14 yields exponent field 1.
- Undefined: e<=0 flushes to signed zero {sign,15'h0}, with underflow=1, zero=1, inexact=1.

Decomposition:
- Package fp16_pkg holds:
  - Constants EXP_BIAS=15, EXP_MAX=31, QNAN=16'h7E00, POS_INF=16'h7C00.
  - A struct for {sign, exponent, magnitude, inf, nan}, used as the S1/S2 pipeline payload.
- One sub-module: fp_lzc14, a combinational 14-bit leading-zero counter returning a 4-bit count plus an all-zero flag.

Test Plan:
- exp=15, mag=14'b01_0000000000_00 -> r=16'h3C00 after 3 clk; all flags 0.
- exp=15, mag=14'b10_0000000000_00 -> r=16'h4000. exp=15, mag=14'b00_0000000001_00 (cancellation) -> r=16'h1400.
- Rounding, exp=15:
  - mag=14'b01_0000000001_10 -> r=16'h3C02, inexact=1.
  - mag=14'b01_0000000000_10 -> r=16'h3C00, inexact=1 (tie to even).
- exp=30, mag=14'b11_1111111111_11 -> r=16'h7C00, overflow=1, inexact=1.
- exp=1, mag=14'b00_1000000000_00:
  - Without macro: r=16'h0000, underflow=1, zero=1.
  - With macro: r=16'h0200, underflow=0.
- Stall: stream 4 beats, hold out_ready=0 for 5 clk.
  - in_ready drops; r is held.
  - Order is preserved, with no loss or duplication.
  - Asserting reset mid-stall gives out_valid=0 immediately.
